// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared binary32 field layout, constants, state and operand-class types for the divider
package fp_div_pkg;
  typedef enum logic [1:0] {IDLE, SPECIAL, DIVIDE, ROUND} state_t;
  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} fclass_t;
  localparam int SIGN = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int EXP_W = 8;
  localparam int FRAC_HI = 22;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int EXP_MAX = 255;
  localparam int QBITS = 26;
  // zero exponent flushes denormals to zero; all-ones exponent splits inf/NaN on the fraction
  function automatic fclass_t fp_class(input logic [31:0] x);
    return x[EXP_HI:EXP_LO] == '0 ? CL_ZERO :
           x[EXP_HI:EXP_LO] != EXP_W'(EXP_MAX) ? CL_NORM :
           x[FRAC_HI:0] == '0 ? CL_INF : CL_NAN;
  endfunction
endpackage

// File: rtl/fp_mant_divider.sv
// fp_mant_divider: restoring mantissa divider producing one quotient bit per cycle, MSB first
module fp_mant_divider
  import fp_div_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [QBITS-1:0] ma,
  input  logic [QBITS-1:0] mb,
  output logic [QBITS-1:0] q,
  output logic             sticky,
  output logic             last
);
  logic [QBITS-1:0] r_rem;
  logic [QBITS-1:0] r_q;
  logic [4:0]       r_cnt;
  logic             r_run;
  logic             w_ge;
  assign w_ge = r_rem >= mb;
  assign last = r_run && r_cnt == 5'(QBITS - 1);
  assign q = r_q;
  assign sticky = r_rem != '0;
  // one subtract-or-keep step per cycle; the remainder stays below 2*mb so it never overflows
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rem <= '0;
      r_q <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (load) begin
      r_rem <= ma;
      r_q <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= (w_ge ? r_rem - mb : r_rem) << 1;
      r_q <= {r_q[QBITS-2:0], w_ge};
      r_cnt <= last ? '0 : r_cnt + 5'd1;
      r_run <= !last;
    end
  end
endmodule

// File: rtl/floating_divider.sv
// floating_divider: sequential binary32 divider with start/busy/done handshake and round-to-nearest-even
module floating_divider
  import fp_div_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] c,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);
  state_t             r_state, w_next;
  logic [31:0]        r_a, r_b, r_c;
  logic [QBITS-1:0]   r_mb;
  logic signed [9:0]  r_e;
  logic               r_done, r_inv, r_dbz, r_ovf, r_unf;
  logic               w_accept, w_normal, w_d, w_sign, w_last, w_sticky;
  logic [QBITS-1:0]   w_ma, w_mb, w_q;
  logic signed [9:0]  w_e, w_er;
  fclass_t            w_ca, w_cb;
  logic               w_inv, w_dbz, w_spec_inf, w_inc, w_carry, w_ovf, w_unf;
  logic [23:0]        w_sum;
  logic [31:0]        w_spec_c, w_round_c;
  assign w_accept = r_state == IDLE && start;
  assign w_normal = fp_class(a) == CL_NORM && fp_class(b) == CL_NORM;
  assign w_d = a[FRAC_HI:0] < b[FRAC_HI:0];
  assign w_ma = w_d ? {1'b0, 1'b1, a[FRAC_HI:0], 1'b0} : {2'b00, 1'b1, a[FRAC_HI:0]};
  assign w_mb = {2'b00, 1'b1, b[FRAC_HI:0]};
  assign w_e = $signed({2'b00, a[EXP_HI:EXP_LO]}) - $signed({2'b00, b[EXP_HI:EXP_LO]})
             + 10'sd127 - $signed({9'd0, w_d});
  fp_mant_divider u_mant (
    .CLK   (CLK),
    .RST   (RST),
    .load  (w_accept && w_normal),
    .ma    (w_ma),
    .mb    (r_mb),
    .q     (w_q),
    .sticky(w_sticky),
    .last  (w_last)
  );
  assign w_sign = r_a[SIGN] ^ r_b[SIGN];
  assign w_ca = fp_class(r_a);
  assign w_cb = fp_class(r_b);
  assign w_inv = w_ca == CL_NAN || w_cb == CL_NAN || (w_ca == CL_ZERO && w_cb == CL_ZERO)
               || (w_ca == CL_INF && w_cb == CL_INF);
  assign w_spec_inf = !w_inv && (w_ca == CL_INF || (w_cb == CL_ZERO));
  assign w_dbz = !w_inv && w_ca != CL_INF && w_cb == CL_ZERO;
  assign w_spec_c = w_inv ? QNAN : w_spec_inf ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'd0};
  assign w_inc = w_q[1] & (w_q[0] | w_sticky | w_q[2]);
  assign w_sum = w_q[QBITS-1:2] + 24'(w_inc);
  assign w_carry = w_q[QBITS-1] & !w_sum[23];
  assign w_er = r_e + $signed({9'd0, w_carry});
  assign w_ovf = w_er >= 10'sd255;
  assign w_unf = w_er <= 10'sd0;
  assign w_round_c = w_ovf ? {w_sign, 8'hFF, 23'd0} : w_unf ? {w_sign, 31'd0}
                   : {w_sign, w_er[7:0], w_sum[FRAC_HI:0]};
  // state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state: normal operands iterate then round, everything else takes the one-cycle special path
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (w_normal ? DIVIDE : SPECIAL) : IDLE;
      SPECIAL: w_next = IDLE;
      DIVIDE:  w_next = w_last ? ROUND : DIVIDE;
      ROUND:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // operand capture at accept, result and flag registration at the end of either path
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a <= '0;
      r_b <= '0;
      r_mb <= '0;
      r_e <= '0;
      r_c <= '0;
      r_done <= 1'b0;
      {r_inv, r_dbz, r_ovf, r_unf} <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
        r_mb <= w_mb;
        r_e <= w_e;
        {r_inv, r_dbz, r_ovf, r_unf} <= '0;
      end
      if (r_state == SPECIAL) begin
        r_c <= w_spec_c;
        r_done <= 1'b1;
        r_inv <= w_inv;
        r_dbz <= w_dbz;
      end
      if (r_state == ROUND) begin
        r_c <= w_round_c;
        r_done <= 1'b1;
        r_ovf <= w_ovf;
        r_unf <= !w_ovf && w_unf;
      end
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign c = r_c;
  assign invalid = r_inv;
  assign div_by_zero = r_dbz;
  assign overflow = r_ovf;
  assign underflow = r_unf;
endmodule
